branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor for the 5-stage RISC-V core. It sits beside the fetch stage and provides `prediction` and `predicted_pc` to the decode-side control logic. It carries each prediction alongside its instruction through IF/ID and ID/EX. When EX reports the branch or jump outcome, it updates its target buffer and counters, and signals a misprediction together with the recovery PC.

## Interface
- `IDX_W`, default 4: index bits. Table has 2^IDX_W entries.
- `TAG_W`, default 8: partial tag bits stored per entry.
- `PC_W`, default 64: PC width.
- `clk`  in  1  rising-edge clock.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `fetch_valid`  in  1  IF holds a real instruction this cycle.
- `fetch_pc`  in  PC_W  PC being fetched.
- `prediction`  out  1  predicted taken for `fetch_pc`.
- `predicted_pc`  out  PC_W  predicted next PC.
- `pipe_stall`  in  1  IF/ID and ID/EX hold; shadow stages hold.
- `pipe_flush`  in  1  external flush of IF/ID and ID/EX.
- `resolve_valid`  in  1  EX resolves a control-flow instruction this cycle. One cycle per instruction.
- `resolve_taken`  in  1  actual direction (1 for jumps).
- `resolve_is_jump`  in  1  unconditional jump.
- `resolve_target`  in  PC_W  actual taken target.
- `mispredict`  out  1  the prediction for the resolving instruction was wrong.
- `recovery_pc`  out  PC_W  correct next PC; meaningful only when `mispredict` is 1.

## Operation
- **Index and tag.**
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+2 +: TAG_W].
- **Entry contents:** valid, tag, target (PC_W bits), 2-bit saturating counter `ctr`.
- **Lookup (combinational):**
  - hit = valid[idx] & tag match.
  - `prediction` = hit & ctr[1].
  - `predicted_pc` = `prediction` ? target : `fetch_pc`+4, with modulo 2^PC_W wrap.
- **Shadow pipeline:** two stages S1 (IF/ID) and S2 (ID/EX). Each holds {v, pc, pred_next}.
  - S1 captures {`fetch_valid`, `fetch_pc`, `predicted_pc`}.
  - S2 captures S1.
- **Resolution** applies only when `resolve_valid` & S2.v. If `resolve_valid` is asserted while S2.v=0, it is ignored and the bench flags it as an error.
  - actual = `resolve_taken` ? `resolve_target` : S2.pc+4.
  - `mispredict` = actual != S2.pred_next.
  - `recovery_pc` = actual.
- **Table update** (on resolution, written at the next edge, indexed by S2.pc):
  - Hit, jump: set ctr=11 and update the target.
  - Hit, branch taken: ctr+1, saturating at 11; update the target.
  - Hit, branch not taken: ctr-1, saturating at 00; target unchanged.
  - Miss, taken: allocate with valid=1, new tag, target, ctr=11 for a jump or 10 for a branch.
  - Miss, not taken: no allocation.

## Timing
- **Reset:** all valid bits=0, all ctr=01, S1.v=S2.v=0.
  - After reset, `prediction`=0, `predicted_pc`=`fetch_pc`+4, `mispredict`=0, `recovery_pc`=0.
  - Target and tag arrays need no reset.
- **Latency:**
  - Lookup: 0 cycles.
  - Prediction reaches S2: 2 cycles when no stall.
  - `mispredict`: same cycle as `resolve_valid`.
  - Table write becomes visible to lookup 1 cycle after resolution.
- **Same-index lookup and update in the same cycle:** lookup sees the old contents. No bypass.
- **Shadow update priority** at each edge, highest first:
  1. `pipe_flush` or `mispredict` clears S1.v and S2.v. Both stages flush the same way.
  2. `pipe_stall` holds S1 and S2.
  3. Otherwise the stages shift.
- **Stall during resolution:** a resolution while `pipe_stall`=1 still updates the table exactly once. The environment guarantees `resolve_valid` is not repeated for the held instruction.
- **Counter saturation:** 11 + taken stays 11; 00 + not-taken stays 00.
- **Aliasing:** a tag mismatch at the same idx is a miss. A taken allocation overwrites the victim.
- **Reset mid-operation:** asserting `arst_n` low clears state immediately. No pending update is committed.

## Structure
- **Shared package `bp_pkg`:**
  - Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
  - PC increment constant 4.
  - Struct for the shadow stage {v, pc, pred_next}.
- **Sub-module `bp_sat_counter`:** 2-bit saturating next-state logic with inputs ctr, taken, force_strong; output next ctr. It is instantiated once in the update path.
- **Table storage:** flop arrays inside `branch_predictor`. No SRAM macro.

## Test plan
- **Cold start:** after reset, `fetch_pc`=0x100 -> `prediction`=0, `predicted_pc`=0x104. Resolve taken to 0x200 two cycles later -> `mispredict`=1, `recovery_pc`=0x200.
- **Training:** after that allocation, refetch 0x100 -> `prediction`=1, `predicted_pc`=0x200 (ctr=10). Resolve not taken -> `mispredict`=1, `recovery_pc`=0x104, ctr=01. Next fetch of 0x100 -> `prediction`=0.
- **Jump:** JAL at 0x40 resolved taken to 0x80 with `resolve_is_jump`=1 -> ctr=11. One not-taken resolution still leaves `prediction`=1 (ctr=10).
- **Alias:** entry for 0x100 is valid. Fetch 0x100 + (2^(IDX_W+2+TAG_W)) -> hit=1 (partial-tag alias, expected). Fetch 0x100 + (2^(IDX_W+2)) -> hit=0 and `prediction`=0.
- **Stall and flush:** hold `pipe_stall` 3 cycles with S2 valid -> S2 unchanged and a single resolution updates once. `pipe_flush` and `pipe_stall` together -> S1.v=S2.v=0.
- **Async reset:** drop `arst_n` mid-stream with a trained table -> `prediction`=0 for all PCs, `mispredict`=0, within the same cycle.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the branch predictor
// Contents: counter encodings, PC increment, shadow pipeline stage record.
package bp_pkg;

  // 2-bit direction counter; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam int unsigned PC_INC = 4;

  // Shadow stages are stored at the widest supported PC width; the top
  // only uses the low PC_W bits (PC_W must not exceed BP_PC_W_MAX).
  localparam int unsigned BP_PC_W_MAX = 64;

  typedef struct packed {
    logic                   v;
    logic [BP_PC_W_MAX-1:0] pc;
    logic [BP_PC_W_MAX-1:0] pred_next;
  } stage_t;

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - 2-bit saturating counter next-state logic
// Ports:
//   ctr          in  current counter value
//   taken        in  resolved direction
//   force_strong in  unconditional jump: go straight to strongly taken
//   ctr_next     out updated counter value
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  input  logic       force_strong,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (force_strong) begin
      ctr_next = CTR_ST;
    end else if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB + 2-bit counter branch predictor with shadow pipeline
// Ports:
//   clk, arst_n                      clock, async active-low reset
//   fetch_valid, fetch_pc            instruction in IF
//   prediction, predicted_pc         combinational lookup result for fetch_pc
//   pipe_stall, pipe_flush           IF/ID and ID/EX control
//   resolve_valid/taken/is_jump/target  EX outcome for the instruction in S2
//   mispredict, recovery_pc          redirect request, same cycle as resolution
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8,
  parameter int PC_W  = 64
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            fetch_valid,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            prediction,
  output logic [PC_W-1:0] predicted_pc,
  input  logic            pipe_stall,
  input  logic            pipe_flush,
  input  logic            resolve_valid,
  input  logic            resolve_taken,
  input  logic            resolve_is_jump,
  input  logic [PC_W-1:0] resolve_target,
  output logic            mispredict,
  output logic [PC_W-1:0] recovery_pc
);

  localparam int ENTRIES = 1 << IDX_W;

  // Table storage
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];

  // Shadow pipeline
  stage_t s1_q, s1_d;
  stage_t s2_q, s2_d;

  // ---------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[IDX_W+2 +: TAG_W];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign prediction   = f_hit && ctr_q[f_idx][1];
  assign predicted_pc = prediction ? target_q[f_idx] : fetch_pc + PC_W'(PC_INC);

  // ---------------------------------------------------------------------
  // Resolution
  // ---------------------------------------------------------------------
  logic [PC_W-1:0]  s2_pc;
  logic [PC_W-1:0]  s2_pred_next;
  logic             res_apply;
  logic [PC_W-1:0]  actual_pc;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic [1:0]       ctr_in;
  logic [1:0]       ctr_upd;

  assign s2_pc        = s2_q.pc[PC_W-1:0];
  assign s2_pred_next = s2_q.pred_next[PC_W-1:0];

  // A resolve strobe with no valid instruction in S2 has nothing to act on.
  assign res_apply = resolve_valid && s2_q.v;
  assign actual_pc = resolve_taken ? resolve_target : s2_pc + PC_W'(PC_INC);

  assign mispredict  = res_apply && (actual_pc != s2_pred_next);
  assign recovery_pc = res_apply ? actual_pc : '0;

  assign r_idx = s2_pc[IDX_W+1:2];
  assign r_tag = s2_pc[IDX_W+2 +: TAG_W];
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  // On a miss the counter starts from WNT, so one taken step lands on WT
  // for a branch and force_strong lands on ST for a jump: the allocation
  // values fall out of the same counter logic as a hit.
  assign ctr_in = r_hit ? ctr_q[r_idx] : CTR_WNT;

  bp_sat_counter u_sat_counter (
    .ctr          (ctr_in),
    .taken        (resolve_taken),
    .force_strong (resolve_is_jump),
    .ctr_next     (ctr_upd)
  );

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (res_apply) begin
      if (r_hit) begin
        ctr_d[r_idx] = ctr_upd;
        if (resolve_taken) target_d[r_idx] = resolve_target;
      end else if (resolve_taken) begin
        // Taken miss allocates, evicting whatever aliased at this index.
        valid_d[r_idx]  = 1'b1;
        tag_d[r_idx]    = r_tag;
        target_d[r_idx] = resolve_target;
        ctr_d[r_idx]    = ctr_upd;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shadow pipeline: flush beats stall beats shift
  // ---------------------------------------------------------------------
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (pipe_flush || mispredict) begin
      s1_d.v = 1'b0;
      s2_d.v = 1'b0;
    end else if (!pipe_stall) begin
      s1_d.v         = fetch_valid;
      s1_d.pc        = BP_PC_W_MAX'(fetch_pc);
      s1_d.pred_next = BP_PC_W_MAX'(predicted_pc);
      s2_d           = s1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  // Tags and targets are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule
